// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-2 valid/ready stream demux; DEMUX_COUNT_EN adds per-lane drain counters cnt0/cnt1
module demux_stream #(
  parameter int WIDTH = 32
`ifdef DEMUX_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  input  logic             sel,
  output logic             i_ready,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready
`ifdef DEMUX_COUNT_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);
  logic drain0, drain1, acc0, acc1;
  assign drain0  = y0_valid && y0_ready;
  assign drain1  = y1_valid && y1_ready;
  assign i_ready = sel ? (!y1_valid || y1_ready) : (!y0_valid || y0_ready);
  assign acc0    = i_valid && i_ready && !sel;
  assign acc1    = i_valid && i_ready && sel;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0       <= '0;
      y1       <= '0;
      y0_valid <= 1'b0;
      y1_valid <= 1'b0;
    end else begin
      if (acc0) y0 <= i;
      if (acc1) y1 <= i;
      y0_valid <= acc0 || (y0_valid && !y0_ready);
      y1_valid <= acc1 || (y1_valid && !y1_ready);
    end
  end
`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0) cnt0 <= cnt0 + 1'b1;
      if (drain1) cnt1 <= cnt1 + 1'b1;
    end
  end
`endif
endmodule
